// File: rtl/timer_dev_pkg.sv
// timer_dev shared definitions: register offsets, FSM states, CTRL layout.
// Imported by the timer, its byte-lane merge and the bus interface users.
package timer_dev_pkg;

  localparam logic [1:0] REG_CTRL   = 2'd0;
  localparam logic [1:0] REG_PRESET = 2'd1;
  localparam logic [1:0] REG_COUNT  = 2'd2;
  localparam logic [1:0] REG_RSVD   = 2'd3;

  localparam logic [1:0] MODE_ONE  = 2'b00;
  localparam logic [1:0] MODE_AUTO = 2'b01;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_CNT  = 2'd2,
    ST_INT  = 2'd3
  } state_t;

  // CTRL[3]=IM, CTRL[2:1]=MODE, CTRL[0]=EN
  typedef struct packed {
    logic       im;
    logic [1:0] mode;
    logic       en;
  } ctrl_t;

  function automatic logic [31:0] lane_mask(
    input logic [3:0] be
  );
    return {{8{be[3]}}, {8{be[2]}},
            {8{be[1]}}, {8{be[0]}}};
  endfunction

endpackage

// File: rtl/timer_dev_if.sv
// timer_dev_if: word-addressed store/load bus between bridge and timer.
// master = bridge side (drives addr/we/be/wdata), slave = device (rdata).
interface timer_dev_if;

  logic [1:0]  addr;
  logic        we;
  logic [3:0]  be;
  logic [31:0] wdata;
  logic [31:0] rdata;

  modport master (
    output addr, we, be, wdata,
    input  rdata
  );

  modport slave (
    input  addr, we, be, wdata,
    output rdata
  );

endinterface

// File: rtl/timer_dev_be_merge.sv
// timer_dev_be_merge: combinational byte-lane merge of a store into a word.
// Ports: old_word/new_word (32), be (4) lane enables -> merged (32).
module timer_dev_be_merge
  import timer_dev_pkg::*;
(
  input  logic [31:0] old_word,
  input  logic [31:0] new_word,
  input  logic [3:0]  be,
  output logic [31:0] merged
);

  logic [31:0] mask;

  assign mask   = lane_mask(be);
  assign merged = (old_word & ~mask)
                | (new_word & mask);

endmodule

// File: rtl/timer_dev.sv
// timer_dev: memory-mapped 32-bit down-counting timer with irq to CP0.
// Ports: clk, reset (sync, active-high), bus (timer_dev_if.slave), irq.
module timer_dev
  import timer_dev_pkg::*;
#(
  parameter logic [31:0] PRESET_INIT = 32'h0,
  parameter logic [31:0] CNT_RESET   = 32'h0
) (
  input  logic        clk,
  input  logic        reset,
  timer_dev_if.slave  bus,
  output logic        irq
);

  ctrl_t       ctrl;
  logic [31:0] preset;
  logic [31:0] count;
  state_t      state;
  logic        int_pend;

  logic        wr_any;
  logic        ctrl_wr;
  logic        preset_wr;
  logic [31:0] old_word;
  logic [31:0] merged;

  // An all-zero byte enable is a no-op, including
  // the int_pend clear side effect.
  assign wr_any    = bus.we && (bus.be != 4'b0000);
  assign ctrl_wr   = wr_any && (bus.addr == REG_CTRL);
  assign preset_wr = wr_any && (bus.addr == REG_PRESET);

  assign old_word = (bus.addr == REG_CTRL)
                  ? {28'h0, ctrl}
                  : preset;

  timer_dev_be_merge u_merge (
    .old_word (old_word),
    .new_word (bus.wdata),
    .be       (bus.be),
    .merged   (merged)
  );

  always_comb begin
    bus.rdata = 32'h0;
    unique case (bus.addr)
      REG_CTRL:   bus.rdata = {28'h0, ctrl};
      REG_PRESET: bus.rdata = preset;
      REG_COUNT:  bus.rdata = count;
      default:    bus.rdata = 32'h0;
    endcase
  end

  assign irq = ctrl.im & int_pend;

  // Bus writes are placed after the FSM so that a
  // CTRL write in INT beats the FSM clearing EN, and
  // a CTRL/PRESET write beats int_pend being set.
  always_ff @(posedge clk) begin
    if (reset) begin
      ctrl     <= '0;
      preset   <= PRESET_INIT;
      count    <= CNT_RESET;
      state    <= ST_IDLE;
      int_pend <= 1'b0;
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (ctrl.en)
            state <= ST_LOAD;
        end
        ST_LOAD: begin
          count <= preset;
          state <= ST_CNT;
        end
        ST_CNT: begin
          if (!ctrl.en) begin
            state <= ST_IDLE;
          end else if (count > 32'd1) begin
            count <= count - 32'd1;
          end else begin
            count    <= 32'h0;
            int_pend <= 1'b1;
            state    <= ST_INT;
          end
        end
        ST_INT: begin
          if (ctrl.mode == MODE_AUTO)
            int_pend <= 1'b0;
          else
            ctrl.en  <= 1'b0;
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase

      if (ctrl_wr)
        ctrl <= ctrl_t'(merged[3:0]);
      if (preset_wr)
        preset <= merged;
      if (ctrl_wr || preset_wr)
        int_pend <= 1'b0;
    end
  end

endmodule

// File: tb/tb_timer_dev.sv
// tb_timer_dev: directed self-checking bench for timer_dev.
// Drives the bus interface, checks rdata/irq/state against hand values.
module tb_timer_dev;
  import timer_dev_pkg::*;

  logic clk;
  logic reset;
  logic irq;
  int   checks;
  int   errors;

  timer_dev_if bus ();

  timer_dev #(
    .PRESET_INIT (32'h0),
    .CNT_RESET   (32'h0)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus),
    .irq   (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(
    input string       tag,
    input logic [31:0] obs,
    input logic [31:0] exp
  );
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %h expected %h",
             tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(
    input logic [1:0]  a,
    input logic [3:0]  b,
    input logic [31:0] d
  );
    bus.addr  = a;
    bus.be    = b;
    bus.wdata = d;
    bus.we    = 1'b1;
    tick();
    bus.we    = 1'b0;
    bus.be    = 4'b0000;
  endtask

  task automatic rd(
    input string       tag,
    input logic [1:0]  a,
    input logic [31:0] exp
  );
    bus.addr = a;
    #1;
    chk(tag, bus.rdata, exp);
  endtask

  initial begin
    logic [31:0] cpat [6];
    checks    = 0;
    errors    = 0;
    reset     = 1'b1;
    bus.addr  = REG_CTRL;
    bus.we    = 1'b0;
    bus.be    = 4'b0000;
    bus.wdata = 32'h0;
    cpat      = '{32'd3, 32'd2, 32'd1,
                  32'd0, 32'd0, 32'd0};
    tick();
    tick();
    reset = 1'b0;

    chk("rst_irq", {31'h0, irq}, 32'h0);
    rd("rst_ctrl", REG_CTRL, 32'h0);
    rd("rst_preset", REG_PRESET, 32'h0);
    rd("rst_count", REG_COUNT, 32'h0);

    // one-shot, PRESET=5, EN|IM
    wr(REG_PRESET, 4'hF, 32'd5);
    wr(REG_CTRL, 4'hF, 32'h9);
    tick();
    chk("os_load", 32'(dut.state), 32'(ST_LOAD));
    tick();
    rd("os_c5", REG_COUNT, 32'd5);
    for (int v = 4; v >= 1; v--) begin
      tick();
      rd("os_cnt", REG_COUNT, 32'(v));
    end
    tick();
    rd("os_c0", REG_COUNT, 32'd0);
    chk("os_irq", {31'h0, irq}, 32'h1);
    tick();
    rd("os_ctrl8", REG_CTRL, 32'h8);
    chk("os_irq_hold", {31'h0, irq}, 32'h1);
    tick();
    chk("os_irq_hold2", {31'h0, irq}, 32'h1);
    rd("os_c0_hold", REG_COUNT, 32'd0);
    wr(REG_CTRL, 4'hF, 32'h8);
    chk("os_irq_clr", {31'h0, irq}, 32'h0);

    // auto-reload, PRESET=3, EN|AUTO|IM
    wr(REG_PRESET, 4'hF, 32'd3);
    wr(REG_CTRL, 4'hF, 32'hB);
    tick();
    tick();
    for (int j = 0; j < 12; j++) begin
      rd("ar_count", REG_COUNT, cpat[j % 6]);
      chk("ar_irq", {31'h0, irq},
          {31'h0, (j % 6) == 3});
      tick();
    end
    wr(REG_CTRL, 4'hF, 32'h0);
    tick();

    // byte lanes
    wr(REG_PRESET, 4'hF, 32'hAABBCCDD);
    rd("bl_full", REG_PRESET, 32'hAABBCCDD);
    wr(REG_PRESET, 4'b0010, 32'h00001100);
    rd("bl_sb", REG_PRESET, 32'hAABB11DD);
    wr(REG_PRESET, 4'b1100, 32'h12340000);
    rd("bl_sh", REG_PRESET, 32'h123411DD);
    wr(REG_PRESET, 4'b0000, 32'hFFFFFFFF);
    rd("bl_none", REG_PRESET, 32'h123411DD);
    wr(REG_CTRL, 4'hF, 32'hFFFFFFF6);
    rd("bl_ctrl_hi", REG_CTRL, 32'h6);
    wr(REG_CTRL, 4'hF, 32'h0);

    // stop / resume, PRESET=10
    wr(REG_PRESET, 4'hF, 32'd10);
    wr(REG_CTRL, 4'hF, 32'h1);
    tick();
    tick();
    rd("sr_c10", REG_COUNT, 32'd10);
    tick();
    tick();
    tick();
    wr(REG_CTRL, 4'hF, 32'h0);
    tick();
    rd("sr_frozen", REG_COUNT, 32'd6);
    chk("sr_idle", 32'(dut.state), 32'(ST_IDLE));
    tick();
    rd("sr_frozen2", REG_COUNT, 32'd6);
    wr(REG_CTRL, 4'hF, 32'h1);
    tick();
    tick();
    rd("sr_reload", REG_COUNT, 32'd10);
    wr(REG_CTRL, 4'hF, 32'h0);
    tick();

    // edges: PRESET=0, IM=0
    wr(REG_PRESET, 4'hF, 32'd0);
    wr(REG_CTRL, 4'hF, 32'h1);
    tick();
    tick();
    chk("e0_cnt", 32'(dut.state), 32'(ST_CNT));
    tick();
    chk("e0_int", 32'(dut.state), 32'(ST_INT));
    chk("e0_pend", {31'h0, dut.int_pend}, 32'h1);
    chk("e0_irq_masked", {31'h0, irq}, 32'h0);
    tick();
    rd("e0_en_clr", REG_CTRL, 32'h0);
    wr(REG_COUNT, 4'hF, 32'h1234);
    rd("e0_cnt_ro", REG_COUNT, 32'h0);
    wr(REG_RSVD, 4'hF, 32'hDEAD);
    rd("e0_rsvd", REG_RSVD, 32'h0);
    rd("e0_preset", REG_PRESET, 32'h0);

    // CTRL write during INT wins over EN clear
    wr(REG_CTRL, 4'hF, 32'h9);
    tick();
    tick();
    tick();
    chk("sim_irq", {31'h0, irq}, 32'h1);
    wr(REG_CTRL, 4'hF, 32'h9);
    rd("sim_ctrl", REG_CTRL, 32'h9);
    chk("sim_irq_clr", {31'h0, irq}, 32'h0);
    wr(REG_CTRL, 4'hF, 32'h0);
    tick();
    tick();

    // reset mid-count at COUNT=7
    wr(REG_PRESET, 4'hF, 32'd10);
    wr(REG_CTRL, 4'hF, 32'h9);
    tick();
    tick();
    tick();
    tick();
    tick();
    rd("rm_c7", REG_COUNT, 32'd7);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    rd("rm_ctrl", REG_CTRL, 32'h0);
    rd("rm_count", REG_COUNT, 32'h0);
    chk("rm_idle", 32'(dut.state), 32'(ST_IDLE));

    // reset with irq pending
    wr(REG_PRESET, 4'hF, 32'd1);
    wr(REG_CTRL, 4'hF, 32'h9);
    tick();
    tick();
    tick();
    chk("rp_irq", {31'h0, irq}, 32'h1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("rp_irq_low", {31'h0, irq}, 32'h0);
    rd("rp_preset", REG_PRESET, 32'h0);
    chk("rp_idle", 32'(dut.state), 32'(ST_IDLE));
    tick();
    chk("rp_stay", 32'(dut.state), 32'(ST_IDLE));

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
